// File: rtl/ares_capture_pkg.sv
// Shared types and lane helpers for the trigger-armed ADC capture buffer.
// Optional drop/stall reporting is enabled by defining ARES_CAPTURE_DROP_CNT_EN.
package ares_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } capture_state_t;

  // Upper bounds for the helpers: 16 lanes of up to 32-bit samples, outputs up to 64 bits.
  localparam int MAX_SAMPLE_W = 32;
  localparam int MAX_TDATA_W  = 512;
  localparam int MAX_OUT_W    = 64;

  function automatic logic [MAX_SAMPLE_W-1:0] lane_extract(
    input logic [MAX_TDATA_W-1:0] beat,
    input int                     lane,
    input int                     sample_w
  );
    logic [MAX_SAMPLE_W-1:0] ones;
    ones = '1;
    return MAX_SAMPLE_W'(beat >> (lane * sample_w)) & ~(ones << sample_w);
  endfunction

  function automatic logic [MAX_OUT_W-1:0] sample_extend(
    input logic [MAX_SAMPLE_W-1:0] sample,
    input int                      sample_w,
    input logic                    sign_en
  );
    logic [MAX_OUT_W-1:0] ones;
    logic [MAX_OUT_W-1:0] r;
    ones = '1;
    r    = MAX_OUT_W'(sample);
    if (sign_en && 1'(sample >> (sample_w - 1))) r = r | (ones << sample_w);
    return r;
  endfunction

endpackage

// File: rtl/ares_capture_ram.sv
// Simple dual-port inferred RAM holding captured ADC beats; one-cycle registered read.
module ares_capture_ram
  import ares_capture_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ares_capture_fifo.sv
// Trigger-armed capture buffer: stores CAPTURE_BEATS wide ADC beats, then drains them one sample per beat.
// Define ARES_CAPTURE_DROP_CNT_EN to add the dropped_triggers / fill_stall_cycles status outputs.
module ares_capture_fifo
  import ares_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH           = 16,
  parameter int SAMPLES_PER_BEAT       = 8,
  parameter int CAPTURE_BEATS          = 128,
  parameter int C_S00_AXIS_TDATA_WIDTH = 128,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SIGN_EXTEND            = 1
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  laser_trigger,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  busy,
`ifdef ARES_CAPTURE_DROP_CNT_EN
  output logic [15:0]                           dropped_triggers,
  output logic [15:0]                           fill_stall_cycles,
`endif
  output logic                                  capture_done
);

  localparam int AW = $clog2(CAPTURE_BEATS);
  localparam int LW = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;
  localparam logic [AW-1:0] LAST_BEAT = AW'(CAPTURE_BEATS - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(SAMPLES_PER_BEAT - 1);

  capture_state_t state;
  logic trig_q;
  logic trig_rise;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] obeat;
  logic [LW-1:0] lane;
  logic rd_pending;
  logic rd_all;
  logic cur_vld;
  logic nxt_vld;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] cur_beat;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] nxt_beat;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] rdata;
  logic ram_we;
  logic ram_re;
  logic last_lane;
  logic out_ld;
  logic consume;
  logic xfer_last;
  logic [1:0] occ_next;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] out_sample;
  logic unused_inputs;

  assign s00_axis_tready = 1'b1;
  assign m00_axis_tstrb  = '1;
  assign unused_inputs   = ^{s00_axis_tlast, s00_axis_tstrb};

  assign trig_rise = laser_trigger & ~trig_q;
  assign ram_we    = (state == FILL) && s00_axis_tvalid;
  assign last_lane = (lane == LAST_LANE);
  assign out_ld    = (state == DRAIN) && cur_vld && (!m00_axis_tvalid || m00_axis_tready);
  assign consume   = out_ld && last_lane;
  assign xfer_last = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;

  // A read is issued only if its data will have a free slot (cur/nxt) when it lands next cycle.
  assign occ_next = 2'(cur_vld) + 2'(nxt_vld) + 2'(rd_pending) - 2'(consume);
  assign ram_re   = (state == DRAIN) && !rd_all && (occ_next < 2'd2);

  assign out_sample = C_M00_AXIS_TDATA_WIDTH'(sample_extend(
                        lane_extract(MAX_TDATA_W'(cur_beat), int'(lane), SAMPLE_WIDTH),
                        SAMPLE_WIDTH, SIGN_EXTEND != 0));

  ares_capture_ram #(
    .DEPTH(CAPTURE_BEATS),
    .WIDTH(C_S00_AXIS_TDATA_WIDTH)
  ) u_ram (
    .clk  (s00_axis_aclk),
    .we   (ram_we),
    .waddr(wptr),
    .wdata(s00_axis_tdata),
    .re   (ram_re),
    .raddr(rptr),
    .rdata(rdata)
  );

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state           <= IDLE;
      trig_q          <= 1'b0;
      wptr            <= '0;
      rptr            <= '0;
      obeat           <= '0;
      lane            <= '0;
      rd_pending      <= 1'b0;
      rd_all          <= 1'b0;
      cur_vld         <= 1'b0;
      nxt_vld         <= 1'b0;
      cur_beat        <= '0;
      nxt_beat        <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      busy            <= 1'b0;
      capture_done    <= 1'b0;
    end else begin
      trig_q       <= laser_trigger;
      capture_done <= 1'b0;
      rd_pending   <= ram_re;
      case (state)
        IDLE: begin
          if (trig_rise) begin
            state <= FILL;
            busy  <= 1'b1;
            wptr  <= '0;
          end
        end
        FILL: begin
          if (s00_axis_tvalid) begin
            wptr <= wptr + 1'b1;
            if (wptr == LAST_BEAT) begin
              state   <= DRAIN;
              rptr    <= '0;
              obeat   <= '0;
              lane    <= '0;
              rd_all  <= 1'b0;
              cur_vld <= 1'b0;
              nxt_vld <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (ram_re) begin
            rptr <= rptr + 1'b1;
            if (rptr == LAST_BEAT) rd_all <= 1'b1;
          end
          // cur is the beat being unpacked, nxt the prefetched one behind it.
          if (consume) begin
            if (nxt_vld) begin
              cur_beat <= nxt_beat;
              if (rd_pending) nxt_beat <= rdata;
              else            nxt_vld  <= 1'b0;
            end else if (rd_pending) begin
              cur_beat <= rdata;
            end else begin
              cur_vld <= 1'b0;
            end
          end else if (rd_pending) begin
            if (!cur_vld) begin
              cur_beat <= rdata;
              cur_vld  <= 1'b1;
            end else begin
              nxt_beat <= rdata;
              nxt_vld  <= 1'b1;
            end
          end
          if (out_ld) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= out_sample;
            m00_axis_tlast  <= last_lane && (obeat == LAST_BEAT);
            if (last_lane) begin
              lane  <= '0;
              obeat <= obeat + 1'b1;
            end else begin
              lane <= lane + 1'b1;
            end
          end else if (m00_axis_tvalid && m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
          end
          if (xfer_last) begin
            state           <= IDLE;
            busy            <= 1'b0;
            capture_done    <= 1'b1;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARES_CAPTURE_DROP_CNT_EN
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      dropped_triggers  <= '0;
      fill_stall_cycles <= '0;
    end else begin
      if (trig_rise && busy && (dropped_triggers != 16'hFFFF))
        dropped_triggers <= dropped_triggers + 16'd1;
      if ((state == IDLE) && trig_rise)
        fill_stall_cycles <= '0;
      else if ((state == FILL) && !s00_axis_tvalid && (fill_stall_cycles != 16'hFFFF))
        fill_stall_cycles <= fill_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ares_capture_fifo.sv
// Bench for ares_capture_fifo: driver pushes expected samples as beats are written, a negedge monitor pops and compares.
// Status counters are checked when ARES_CAPTURE_DROP_CNT_EN is defined.
module tb_ares_capture_fifo;

  logic clk;
  logic aresetn;
  logic laser_trigger;
  logic s_tvalid, s_tlast, s_tready;
  logic [127:0] s_tdata;
  logic [15:0] s_tstrb;
  logic m_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0] m_tstrb;
  logic busy, capture_done;

  // small configuration: 12-bit samples, 4 lanes, 8 beats
  logic sm_trig, sm_s_tvalid, sm_s_tready, sm_m_tvalid, sm_m_tlast, sm_busy, sm_done;
  logic [47:0] sm_s_tdata;
  logic [31:0] sm_m_tdata;
  logic [3:0] sm_m_tstrb;

`ifdef ARES_CAPTURE_DROP_CNT_EN
  logic [15:0] dropped_triggers, fill_stall_cycles;
  logic [15:0] sm_dropped, sm_stalls;
`endif

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_seen = 0;
  int n_done = 0;
  int exp_drops = 0;
  int ready_mode = 0;

  ares_capture_fifo dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (aresetn),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tready  (s_tready),
    .laser_trigger    (laser_trigger),
    .m00_axis_tready  (m_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .busy             (busy),
`ifdef ARES_CAPTURE_DROP_CNT_EN
    .dropped_triggers (dropped_triggers),
    .fill_stall_cycles(fill_stall_cycles),
`endif
    .capture_done     (capture_done)
  );

  ares_capture_fifo #(
    .SAMPLE_WIDTH(12), .SAMPLES_PER_BEAT(4), .CAPTURE_BEATS(8),
    .C_S00_AXIS_TDATA_WIDTH(48), .C_M00_AXIS_TDATA_WIDTH(32), .SIGN_EXTEND(1)
  ) dut_small (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (aresetn),
    .s00_axis_tvalid  (sm_s_tvalid),
    .s00_axis_tlast   (1'b0),
    .s00_axis_tdata   (sm_s_tdata),
    .s00_axis_tstrb   (6'h3F),
    .s00_axis_tready  (sm_s_tready),
    .laser_trigger    (sm_trig),
    .m00_axis_tready  (1'b1),
    .m00_axis_tvalid  (sm_m_tvalid),
    .m00_axis_tlast   (sm_m_tlast),
    .m00_axis_tdata   (sm_m_tdata),
    .m00_axis_tstrb   (sm_m_tstrb),
    .busy             (sm_busy),
`ifdef ARES_CAPTURE_DROP_CNT_EN
    .dropped_triggers (sm_dropped),
    .fill_stall_cycles(sm_stalls),
`endif
    .capture_done     (sm_done)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // tready driver: 0 = always ready, 1 = random 50%, 2 = held low
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  // monitor / scoreboard
  logic        stall_prev = 1'b0;
  logic [32:0] stall_word;
  logic        done_expect = 1'b0;
  logic [32:0] exp_word;

  always @(negedge clk) begin
    if (aresetn) begin
      if (stall_prev) begin
        check("hold_tvalid", 64'(m_tvalid), 64'd1);
        check("hold_payload", 64'({m_tlast, m_tdata}), 64'(stall_word));
      end
      if (done_expect || capture_done) begin
        check("capture_done", 64'(capture_done), 64'(done_expect));
        check("tvalid_after_last", 64'(m_tvalid), 64'd0);
      end
      if (capture_done) n_done++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sample: got %0h expected nothing (queue empty)", {m_tlast, m_tdata});
        end else begin
          exp_word = exp_q.pop_front();
          check("sample", 64'({m_tlast, m_tdata}), 64'(exp_word));
        end
        n_seen++;
      end
      done_expect = m_tvalid && m_tready && m_tlast;
      stall_prev  = m_tvalid && !m_tready;
      stall_word  = {m_tlast, m_tdata};
    end else begin
      done_expect = 1'b0;
      stall_prev  = 1'b0;
    end
  end

  // driver: one full capture with the given fill/drain stimulus
  task automatic run_capture(input int toggle, input logic [15:0] base, input int rmode,
                             input int extra_trig, input int hold_trig, input int reset_at);
    int k, stalls, lat, budget;
    logic ph, drain_trig_done, pulse;
    logic [15:0] v;
    n_seen = 0;
    n_done = 0;
    ready_mode = rmode;
    @(negedge clk);
    laser_trigger = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = {8{16'hDEAD}};
    @(negedge clk);
    check("busy_in_fill", 64'(busy), 64'd1);
    laser_trigger = 1'(hold_trig);
    k = 0; stalls = 0; ph = 1'b0;
    while (k < 128) begin
      pulse = (extra_trig != 0) && (k == 64) && !ph;
      laser_trigger = (hold_trig != 0) || pulse;
      if (pulse) begin
        exp_drops++;
        check("busy_fill_retrigger", 64'(busy), 64'd1);
      end
      if (ph) begin
        s_tvalid = 1'b0;
        s_tdata = '0;
        stalls++;
      end else begin
        s_tvalid = 1'b1;
        for (int j = 0; j < 8; j++) begin
          v = base + 16'(k * 8 + j);
          s_tdata[j*16 +: 16] = v;
          exp_q.push_back({((k == 127) && (j == 7)), sext16(v)});
        end
        k++;
      end
      if (toggle != 0) ph = !ph;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    laser_trigger = 1'(hold_trig);
    lat = 1;
    while (!m_tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", 64'(lat), 64'd4);

    if (reset_at > 0) begin
      budget = 0;
      while (n_seen < reset_at && budget < 5000) begin
        @(negedge clk);
        #1;
        budget++;
      end
      aresetn = 1'b0;
      ready_mode = 2;
      m_tready = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_tvalid", 64'(m_tvalid), 64'd0);
      check("abort_tlast", 64'(m_tlast), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(capture_done), 64'd0);
      aresetn = 1'b1;
      ready_mode = 0;
      exp_drops = 0;
      repeat (3) @(negedge clk);
      check("idle_after_abort", 64'(busy), 64'd0);
      return;
    end

    budget = 0;
    drain_trig_done = 1'b0;
    while (busy && budget < 6000) begin
      laser_trigger = 1'(hold_trig);
      if ((extra_trig != 0) && !drain_trig_done && n_seen >= 500) begin
        laser_trigger = 1'b1;
        drain_trig_done = 1'b1;
        exp_drops++;
        check("busy_drain_retrigger", 64'(busy), 64'd1);
      end
      @(negedge clk);
      budget++;
    end
    laser_trigger = 1'(hold_trig);
    #1;
    check("drain_complete", 64'(busy), 64'd0);
    check("sample_count", 64'(n_seen), 64'd1024);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_pulses", 64'(n_done), 64'd1);
    if (hold_trig != 0) begin
      repeat (5) @(negedge clk);
      check("held_trigger_no_rearm", 64'(busy), 64'd0);
      laser_trigger = 1'b0;
    end
`ifdef ARES_CAPTURE_DROP_CNT_EN
    check("dropped_triggers", 64'(dropped_triggers), 64'(exp_drops));
    check("fill_stall_cycles", 64'(fill_stall_cycles), 64'(stalls));
`endif
    ready_mode = 0;
    @(negedge clk);
  endtask

  task automatic run_small();
    int n, budget;
    logic [11:0] v;
    @(negedge clk);
    sm_trig = 1'b1;
    @(negedge clk);
    sm_trig = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sm_s_tvalid = 1'b1;
      for (int j = 0; j < 4; j++) begin
        v = 12'h800 | 12'(k * 4 + j);
        sm_s_tdata[j*12 +: 12] = v;
      end
      @(negedge clk);
    end
    sm_s_tvalid = 1'b0;
    n = 0;
    budget = 0;
    while (!sm_done && budget < 200) begin
      if (sm_m_tvalid) begin
        n++;
        check("small_sample", 64'(sm_m_tdata), 64'(32'hFFFFF800 | 32'(n - 1)));
        check("small_tlast", 64'(sm_m_tlast), 64'(n == 32));
      end
      @(negedge clk);
      budget++;
    end
    check("small_count", 64'(n), 64'd32);
    check("small_done", 64'(sm_done), 64'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    laser_trigger = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    s_tstrb = '1;
    m_tready = 1'b1;
    sm_trig = 1'b0;
    sm_s_tvalid = 1'b0;
    sm_s_tdata = '0;
    repeat (3) @(negedge clk);
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_tlast", 64'(m_tlast), 64'd0);
    check("reset_tdata", 64'(m_tdata), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(capture_done), 64'd0);
    check("s_tready_const", 64'(s_tready), 64'd1);
    check("m_tstrb_ones", 64'(m_tstrb), 64'hF);
`ifdef ARES_CAPTURE_DROP_CNT_EN
    check("reset_dropped", 64'(dropped_triggers), 64'd0);
    check("reset_stalls", 64'(fill_stall_cycles), 64'd0);
`endif
    aresetn = 1'b1;
    @(negedge clk);
    run_capture(0, 16'h0000, 0, 0, 0, 0);   // ramp, full rate
    run_capture(1, 16'hFC00, 0, 0, 0, 0);   // tvalid toggling, negative samples
    run_capture(0, 16'h0000, 1, 0, 0, 0);   // random tready
    run_capture(0, 16'h1234, 0, 1, 0, 0);   // retriggers mid-fill and mid-drain
    run_capture(0, 16'h0000, 0, 0, 0, 300); // reset mid-drain
    run_capture(0, 16'h0000, 0, 0, 1, 0);   // fresh capture, trigger held high
    run_small();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
